mux4_sel: RTL and testbench

- Registered N-way word multiplexer that selects one of NUM_IN input channels by a binary select.
- Default configuration is a 4:1 single-bit mux with a clocked output.
- Sits in datapaths where a source is steered onto a shared bus.
- Out-of-range selects are flagged rather than aliased.

---
 rtl/mux4_sel_if.sv | 30 +++
 rtl/mux4_sel.sv | 55 +++++
 tb/tb_mux4_sel.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux4_sel_if.sv
// rtl/mux4_sel_if.sv - channel/select/enable bundle for the mux4_sel word multiplexer
interface mux4_sel_if #(
  parameter int WIDTH  = 1,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in;
  logic [SEL_W-1:0]        select;
  logic                    en;
  logic [WIDTH-1:0]        out;
  logic                    sel_err;

  // Source side: drives channels, select and enable; observes the steered word
  modport master (
    output in,
    output select,
    output en,
    input  out,
    input  sel_err
  );

  // Multiplexer side
  modport slave (
    input  in,
    input  select,
    input  en,
    output out,
    output sel_err
  );
endinterface

// File: rtl/mux4_sel.sv
// rtl/mux4_sel.sv - N-way word multiplexer with optional registered output and bad-select flag
module mux4_sel #(
  parameter int WIDTH   = 1,
  parameter int NUM_IN  = 4,
  parameter int SEL_W   = 2,
  parameter int OUT_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  mux4_sel_if.slave   bus
);

  logic [WIDTH-1:0] sel_val;
  logic             err_val;

  // Decode the select against every real channel; codes with no channel fall
  // through to zero data plus the error flag, so unused codes never yield X
  always_comb begin
    sel_val = '0;
    err_val = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.select == SEL_W'(k)) begin
        sel_val = bus.in[k*WIDTH +: WIDTH];
        err_val = 1'b0;
      end
    end
  end

  if (OUT_REG != 0) begin : g_reg
    logic [WIDTH-1:0] out_q;
    logic             err_q;

    // Capture on enabled edges; reset clears both outputs without waiting for clk
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q <= '0;
        err_q <= 1'b0;
      end else if (bus.en) begin
        out_q <= sel_val;
        err_q <= err_val;
      end
    end

    assign bus.out     = out_q;
    assign bus.sel_err = err_q;
  end else begin : g_comb
    // Clock, reset and enable are intentionally inert in the combinational build
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst, bus.en};

    assign bus.out     = sel_val;
    assign bus.sel_err = err_val;
  end

endmodule

// File: tb/tb_mux4_sel.sv
// tb/tb_mux4_sel.sv - self-checking bench for mux4_sel (4:1 registered, 3:1 registered and combinational)
module tb_mux4_sel;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux4_sel_if #(.WIDTH(1), .NUM_IN(4), .SEL_W(2)) ifa ();
  mux4_sel_if #(.WIDTH(2), .NUM_IN(3), .SEL_W(2)) ifb ();
  mux4_sel_if #(.WIDTH(2), .NUM_IN(3), .SEL_W(2)) ifc ();

  mux4_sel #(.WIDTH(1), .NUM_IN(4), .SEL_W(2), .OUT_REG(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mux4_sel #(.WIDTH(2), .NUM_IN(3), .SEL_W(2), .OUT_REG(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  mux4_sel #(.WIDTH(2), .NUM_IN(3), .SEL_W(2), .OUT_REG(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  // Reference model state for the registered instances
  logic [31:0] exp_a, exp_b;
  logic        exp_ea, exp_eb;

  function automatic logic [31:0] ref_val(logic [31:0] data, int sel, int n, int w);
    if (sel >= n) return 32'd0;
    return (data >> (sel * w)) & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic ref_err(int sel, int n);
    return sel >= n;
  endfunction

  // One clock: model captures what is present before the edge, outputs sampled 1ns after
  task automatic tick();
    if (ifa.en) begin
      exp_a  = ref_val(32'(ifa.in), int'(ifa.select), 4, 1);
      exp_ea = ref_err(int'(ifa.select), 4);
    end
    if (ifb.en) begin
      exp_b  = ref_val(32'(ifb.in), int'(ifb.select), 3, 2);
      exp_eb = ref_err(int'(ifb.select), 3);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_a = 0; exp_ea = 0; exp_b = 0; exp_eb = 0;
    end
  endtask

  task automatic test_reset();
    ifa.in = 4'b1111; ifa.select = 2'd0; ifa.en = 1'b1;
    ifb.in = 6'b111111; ifb.select = 2'd1; ifb.en = 1'b1;
    ifc.in = 6'b000000; ifc.select = 2'd0; ifc.en = 1'b1;
    exp_a = 0; exp_ea = 0; exp_b = 0; exp_eb = 0;
    #2;
    checks++;
    if (ifa.out !== 1'b0 || ifa.sel_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_a got out=%0h err=%0h exp out=0 err=0", ifa.out, ifa.sel_err);
    end
    @(posedge clk); #1;
    checks++;
    if (ifa.out !== 1'b0 || ifb.out !== 2'b00 || ifb.sel_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_held_en a=%0h b=%0h berr=%0h exp 0 0 0", ifa.out, ifb.out, ifb.sel_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_all_ones();
    ifa.in = 4'b1111; ifa.en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      ifa.select = 2'(s);
      tick();
      checks++;
      if (ifa.out !== 1'b1 || ifa.sel_err !== 1'b0) begin
        failures++;
        $display("FAIL all_ones sel=%0d got out=%0h err=%0h exp out=1 err=0", s, ifa.out, ifa.sel_err);
      end
    end
  endtask

  task automatic test_mapping();
    logic [3:0] pats [2];
    logic [3:0] want [2];
    pats[0] = 4'b0101; want[0] = 4'b0101;
    pats[1] = 4'b0010; want[1] = 4'b0010;
    for (int p = 0; p < 2; p++) begin
      ifa.in = pats[p];
      for (int s = 0; s < 4; s++) begin
        ifa.select = 2'(s);
        tick();
        checks++;
        if (ifa.out !== want[p][s]) begin
          failures++;
          $display("FAIL mapping in=%b sel=%0d got=%0h exp=%0h", pats[p], s, ifa.out, want[p][s]);
        end
      end
    end
  endtask

  task automatic test_bit_order();
    ifa.in = 4'b0100;
    ifa.select = 2'b10;
    tick();
    checks++;
    if (ifa.out !== 1'b1) begin
      failures++;
      $display("FAIL bit_order_sel10 got=%0h exp=1", ifa.out);
    end
    ifa.select = 2'b01;
    tick();
    checks++;
    if (ifa.out !== 1'b0) begin
      failures++;
      $display("FAIL bit_order_sel01 got=%0h exp=0", ifa.out);
    end
  endtask

  task automatic test_enable_hold();
    ifa.in = 4'b0001; ifa.select = 2'd0; ifa.en = 1'b1;
    tick();
    ifa.en = 1'b0; ifa.select = 2'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (ifa.out !== 1'b1) begin
        failures++;
        $display("FAIL enable_hold cycle=%0d got=%0h exp=1", i, ifa.out);
      end
    end
    ifa.en = 1'b1;
    tick();
    checks++;
    if (ifa.out !== 1'b0) begin
      failures++;
      $display("FAIL enable_resume got=%0h exp=0", ifa.out);
    end
  endtask

  task automatic test_reset_mid();
    ifa.in = 4'b0001; ifa.select = 2'd0; ifa.en = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    exp_a = 0; exp_ea = 0; exp_b = 0; exp_eb = 0;
    checks++;
    if (ifa.out !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async got=%0h exp=0", ifa.out);
    end
    #1 rst = 1'b0;
    ifa.en = 1'b0;
    tick();
    checks++;
    if (ifa.out !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hold got=%0h exp=0", ifa.out);
    end
    ifa.en = 1'b1;
    tick();
    checks++;
    if (ifa.out !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_recapture got=%0h exp=1", ifa.out);
    end
  endtask

  task automatic test_out_of_range();
    ifb.in = 6'b111111; ifb.select = 2'd3; ifb.en = 1'b1;
    ifc.in = 6'b111111; ifc.select = 2'd3; ifc.en = 1'b0;
    #1;
    checks++;
    if (ifc.out !== 2'b00 || ifc.sel_err !== 1'b1) begin
      failures++;
      $display("FAIL oor_comb_sel3 got out=%0h err=%0h exp out=0 err=1", ifc.out, ifc.sel_err);
    end
    tick();
    checks++;
    if (ifb.out !== 2'b00 || ifb.sel_err !== 1'b1) begin
      failures++;
      $display("FAIL oor_reg_sel3 got out=%0h err=%0h exp out=0 err=1", ifb.out, ifb.sel_err);
    end
    ifb.select = 2'd2; ifc.select = 2'd2;
    #1;
    checks++;
    if (ifc.out !== 2'b11 || ifc.sel_err !== 1'b0) begin
      failures++;
      $display("FAIL oor_comb_sel2 got out=%0h err=%0h exp out=3 err=0", ifc.out, ifc.sel_err);
    end
    checks++;
    if (ifb.sel_err !== 1'b1) begin
      failures++;
      $display("FAIL oor_reg_latency got err=%0h exp err=1", ifb.sel_err);
    end
    tick();
    checks++;
    if (ifb.out !== 2'b11 || ifb.sel_err !== 1'b0) begin
      failures++;
      $display("FAIL oor_reg_sel2 got out=%0h err=%0h exp out=3 err=0", ifb.out, ifb.sel_err);
    end
    rst = 1'b1;
    #1;
    exp_b = 0; exp_eb = 0; exp_a = 0; exp_ea = 0;
    checks++;
    if (ifc.out !== 2'b11 || ifc.sel_err !== 1'b0) begin
      failures++;
      $display("FAIL comb_ignores_rst got out=%0h err=%0h exp out=3 err=0", ifc.out, ifc.sel_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      ifa.in = 4'($urandom); ifa.select = 2'($urandom); ifa.en = ($urandom_range(0, 3) != 0);
      ifb.in = 6'($urandom); ifb.select = 2'($urandom); ifb.en = ($urandom_range(0, 3) != 0);
      ifc.in = ifb.in; ifc.select = ifb.select; ifc.en = $urandom_range(0, 1) != 0;
      #1;
      checks++;
      if (32'(ifc.out) !== ref_val(32'(ifc.in), int'(ifc.select), 3, 2) ||
          ifc.sel_err !== ref_err(int'(ifc.select), 3)) begin
        failures++;
        $display("FAIL random_comb i=%0d in=%b sel=%0d got out=%0h err=%0h", i, ifc.in, ifc.select, ifc.out, ifc.sel_err);
      end
      tick();
      checks++;
      if (32'(ifa.out) !== exp_a || ifa.sel_err !== exp_ea) begin
        failures++;
        $display("FAIL random_a i=%0d got out=%0h err=%0h exp out=%0h err=%0h", i, ifa.out, ifa.sel_err, exp_a, exp_ea);
      end
      checks++;
      if (32'(ifb.out) !== exp_b || ifb.sel_err !== exp_eb) begin
        failures++;
        $display("FAIL random_b i=%0d got out=%0h err=%0h exp out=%0h err=%0h", i, ifb.out, ifb.sel_err, exp_b, exp_eb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_mapping();
    test_bit_order();
    test_enable_hold();
    test_reset_mid();
    test_out_of_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
